// File: rtl/xor_share_arb.sv
// Round-robin arbiter sharing one registered XOR unit between NREQ requesters.
// Optional per-channel grant counters are enabled by defining XOR_SHARE_ARB_STATS_EN.
module xor_share_arb #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8,
  parameter int IDW   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
  output logic [IDW-1:0]          rsp_id,
  output logic                    arb_state
`ifdef XOR_SHARE_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]      grant_cnt
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. req_ready is combinational; rsp_valid/rsp_data/rsp_id are
  // registered and held stable while rsp_valid=1 and rsp_ready=0.

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [IDW-1:0]     ptr_q;
  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     grant_idx;
  logic               found;
  logic               can_accept;
  logic               accept;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;

  assign rsp_valid  = (state_q == FULL);
  assign arb_state  = state_q;
  assign can_accept = !rsp_valid || rsp_ready;

  // Search begins at ptr and wraps, so the last-served channel goes to the back.
  always_comb begin
    int cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  assign req_ready = (can_accept && !rst) ? grant : '0;
  assign accept    = found && can_accept && !rst;
  assign a_sel     = req_a[int'(grant_idx)*WIDTH +: WIDTH];
  assign b_sel     = req_b[int'(grant_idx)*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = FULL;
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      ptr_q    <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_data <= a_sel ^ b_sel;
        rsp_id   <= grant_idx;
        ptr_q    <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
      end
    end
  end

`ifdef XOR_SHARE_ARB_STATS_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_stats
    logic [15:0] cnt_q;
    // Saturate rather than wrap so a long-running count never looks small.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (accept && grant[g] && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign grant_cnt[g*16 +: 16] = cnt_q;
  end
`endif

endmodule
